// File: rtl/minialu_operand_seq_if.sv
// Switch/button inputs and registered operand outputs between the board and the
// MiniALU operand sequencer.
interface minialu_operand_seq_if;
  logic [3:0] sw;
  logic       btn_load;
  logic       btn_clear;
  logic [3:0] A;
  logic [3:0] B;
  logic       SA;
  logic       SB;
  logic       Cin;
  logic       valid;
  logic [1:0] state;

  modport master (
    output sw, btn_load, btn_clear,
    input  A, B, SA, SB, Cin, valid, state
  );

  modport slave (
    input  sw, btn_load, btn_clear,
    output A, B, SA, SB, Cin, valid, state
  );
endinterface

// File: rtl/minialu_operand_seq.sv
// Operand sequencer: loads A, B and {Cin,SB,SA} from one 4-bit switch bank over three
// button presses. Optional macro DEBOUNCE_EN adds a DB_CYCLES debounce on both buttons.
module minialu_operand_seq #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  minialu_operand_seq_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_A  = 2'b00,
    WAIT_B  = 2'b01,
    WAIT_OP = 2'b10,
    READY   = 2'b11
  } state_t;

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  state_t     state_q, state_n;
  logic [3:0] a_q, a_n, b_q, b_n;
  logic [2:0] op_q, op_n;
  logic       valid_q, valid_n;

  logic ld_p0, ld_p1, clr_p0, clr_p1;
  logic ld_acc, clr_acc, ld_prev, run_q;
  logic load_pulse;
  logic sw3_unused;

  assign sw3_unused = bus.sw[3];

  // stage p0/p1: two-flop synchronizers; run_q keeps the first edge after reset release idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_p0   <= 1'b0;
      ld_p1   <= 1'b0;
      clr_p0  <= 1'b0;
      clr_p1  <= 1'b0;
      ld_prev <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      ld_p0   <= bus.btn_load;
      ld_p1   <= ld_p0;
      clr_p0  <= bus.btn_clear;
      clr_p1  <= clr_p0;
      ld_prev <= ld_acc;
      run_q   <= 1'b1;
    end
  end

`ifdef DEBOUNCE_EN
  logic [7:0] ld_cnt, clr_cnt;

  // Returns {accepted level, counter}: the level flips after DB_CYCLES disagreeing samples.
  function automatic logic [8:0] db_step(input logic smp, input logic acc, input logic [7:0] cnt);
    if (smp == acc)
      return {acc, 8'd0};
    else if (cnt >= DB_LAST)
      return {smp, 8'd0};
    else
      return {acc, cnt + 8'd1};
  endfunction

  // stage p2: debounced accepted levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_acc  <= 1'b0;
      ld_cnt  <= 8'd0;
      clr_acc <= 1'b0;
      clr_cnt <= 8'd0;
    end else begin
      {ld_acc, ld_cnt}   <= db_step(ld_p1, ld_acc, ld_cnt);
      {clr_acc, clr_cnt} <= db_step(clr_p1, clr_acc, clr_cnt);
    end
  end
`else
  logic [7:0] db_last_unused;

  assign db_last_unused = DB_LAST;
  assign ld_acc         = ld_p1;
  assign clr_acc        = clr_p1;
`endif

  assign load_pulse = ld_acc & ~ld_prev & run_q;

  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    valid_n = valid_q;
    if (clr_acc) begin
      state_n = WAIT_A;
      a_n     = '0;
      b_n     = '0;
      op_n    = '0;
      valid_n = 1'b0;
    end else if (load_pulse) begin
      case (state_q)
        WAIT_A: begin
          a_n     = bus.sw;
          state_n = WAIT_B;
        end
        WAIT_B: begin
          b_n     = bus.sw;
          state_n = WAIT_OP;
        end
        WAIT_OP: begin
          op_n    = bus.sw[2:0];
          valid_n = 1'b1;
          state_n = READY;
        end
        READY: begin
          a_n     = bus.sw;
          valid_n = 1'b0;
          state_n = WAIT_B;
        end
        default: state_n = WAIT_A;
      endcase
    end
  end

  // stage out: registered operand set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      op_q    <= op_n;
      valid_q <= valid_n;
    end
  end

  assign bus.A     = a_q;
  assign bus.B     = b_q;
  assign bus.SA    = op_q[0];
  assign bus.SB    = op_q[1];
  assign bus.Cin   = op_q[2];
  assign bus.valid = valid_q;
  assign bus.state = state_q;

endmodule
